// File: rtl/demux_pkg.sv
// Shared definitions for the 1:4 stream demultiplexer.
package demux_pkg;

    // Number of output channels served by one demux.
    localparam int N_CH = 4;

    // Channel select carried alongside each input transfer.
    typedef logic [1:0] ch_sel_t;

endpackage : demux_pkg

// File: rtl/stream_slot.sv
// One-entry register slice: holds a single word until its consumer takes it.
// A load in the same cycle as a drain refills the slot without a bubble.
module stream_slot #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         rdy,
    output logic         vld,
    output logic [W-1:0] y
);

    // Slot state: load wins over drain, drain clears vld, otherwise hold.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of statement or block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
            y   <= '0;
        end else if (load) begin
            vld <= 1'b1;
            y   <= d;
        end else if (vld && rdy) begin
            vld <= 1'b0;
        end
    end

endmodule : stream_slot

// File: rtl/demux_1_4_stream.sv
// 1:4 stream demux: routes each accepted input word to the slot picked by sel.
// Each channel is decoupled; a stalled channel only blocks offers aimed at it.
module demux_1_4_stream
    import demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    d,
    input  ch_sel_t         sel,
    output logic [W-1:0]    y0,
    output logic [W-1:0]    y1,
    output logic [W-1:0]    y2,
    output logic [W-1:0]    y3,
    output logic [N_CH-1:0] vld,
    input  logic [N_CH-1:0] rdy
);

    logic [N_CH-1:0] load;
    logic [W-1:0]    y_arr [N_CH];

    // The selected slot can take a word if it is empty or draining this cycle.
    assign in_ready = ~vld[sel] | rdy[sel];

    // Decode sel into a one-hot load strobe, only on an actual input transfer.
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred for load.
    always_comb begin
        load = '0;
        if (in_valid && in_ready) begin
            load[sel] = 1'b1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_slot
        stream_slot #(.W(W)) u_slot (
            .clk  (clk),
            .rst  (rst),
            .load (load[i]),
            .d    (d),
            .rdy  (rdy[i]),
            .vld  (vld[i]),
            .y    (y_arr[i])
        );
    end

    assign y0 = y_arr[0];
    assign y1 = y_arr[1];
    assign y2 = y_arr[2];
    assign y3 = y_arr[3];

endmodule : demux_1_4_stream

// File: tb/tb_demux_1_4_stream.sv
// Self-checking bench for demux_1_4_stream: directed vector table followed by
// randomized traffic compared against a per-channel queue model.
module tb_demux_1_4_stream;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] d;
    logic [1:0]   sel;
    logic [W-1:0] y0, y1, y2, y3;
    logic [3:0]   vld;
    logic [3:0]   rdy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux_1_4_stream #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .d        (d),
        .sel      (sel),
        .y0       (y0),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
        .vld      (vld),
        .rdy      (rdy)
    );

    logic [W-1:0] ys [4];
    assign ys[0] = y0;
    assign ys[1] = y1;
    assign ys[2] = y2;
    assign ys[3] = y3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic         rst;
        logic         iv;
        logic [W-1:0] d;
        logic [1:0]   sel;
        logic [3:0]   rdy;
        logic         chk_ir;
        logic         ir;
        logic [3:0]   vld;
        logic [W-1:0] y [4];
    } vec_t;

    vec_t vt [16];

    function automatic vec_t mk(logic r, logic iv, logic [W-1:0] dd, logic [1:0] s,
                                logic [3:0] rd, logic ci, logic ir, logic [3:0] v,
                                logic [W-1:0] a0, logic [W-1:0] a1,
                                logic [W-1:0] a2, logic [W-1:0] a3);
        vec_t t;
        t.rst = r; t.iv = iv; t.d = dd; t.sel = s; t.rdy = rd;
        t.chk_ir = ci; t.ir = ir; t.vld = v;
        t.y[0] = a0; t.y[1] = a1; t.y[2] = a2; t.y[3] = a3;
        return t;
    endfunction

    // Reference model: each channel is a queue of capacity one.
    logic [W-1:0] q [4][$];
    logic [W-1:0] last_y [4];

    initial begin
        rst = 1'b1; in_valid = 1'b0; d = '0; sel = '0; rdy = '0;

        //          rst iv  d     sel  rdy     ci  ir  vld      y0    y1    y2    y3
        // reset held 2 cycles with a live offer
        vt[0]  = mk(1, 1, 4'hA, 0, 4'b0000, 0, 0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0);
        vt[1]  = mk(1, 1, 4'hA, 0, 4'b0000, 0, 0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0);
        // route a,b,c,d to channels 0..3 with all consumers ready
        vt[2]  = mk(0, 1, 4'hA, 0, 4'b1111, 1, 1, 4'b0001, 4'hA, 4'h0, 4'h0, 4'h0);
        vt[3]  = mk(0, 1, 4'hB, 1, 4'b1111, 1, 1, 4'b0010, 4'hA, 4'hB, 4'h0, 4'h0);
        vt[4]  = mk(0, 1, 4'hC, 2, 4'b1111, 1, 1, 4'b0100, 4'hA, 4'hB, 4'hC, 4'h0);
        vt[5]  = mk(0, 1, 4'hD, 3, 4'b1111, 1, 1, 4'b1000, 4'hA, 4'hB, 4'hC, 4'hD);
        vt[6]  = mk(0, 0, 4'h0, 3, 4'b1111, 1, 1, 4'b0000, 4'hA, 4'hB, 4'hC, 4'hD);
        // backpressure on ch0 only; ch1 still flows
        vt[7]  = mk(0, 1, 4'h7, 0, 4'b1110, 1, 1, 4'b0001, 4'h7, 4'hB, 4'hC, 4'hD);
        vt[8]  = mk(0, 1, 4'h3, 0, 4'b1110, 1, 0, 4'b0001, 4'h7, 4'hB, 4'hC, 4'hD);
        vt[9]  = mk(0, 1, 4'h5, 1, 4'b1110, 1, 1, 4'b0011, 4'h7, 4'h5, 4'hC, 4'hD);
        vt[10] = mk(0, 1, 4'h3, 0, 4'b1110, 1, 0, 4'b0001, 4'h7, 4'h5, 4'hC, 4'hD);
        // fill ch2 with 9, then drain and refill with 4 in the same cycle
        vt[11] = mk(0, 1, 4'h9, 2, 4'b0000, 1, 1, 4'b0101, 4'h7, 4'h5, 4'h9, 4'hD);
        vt[12] = mk(0, 1, 4'h4, 2, 4'b0100, 1, 1, 4'b0101, 4'h7, 4'h5, 4'h4, 4'hD);
        // fill ch3, then reset mid-operation, then first transfer after reset
        vt[13] = mk(0, 1, 4'h2, 3, 4'b0000, 1, 1, 4'b1101, 4'h7, 4'h5, 4'h4, 4'h2);
        vt[14] = mk(1, 1, 4'hF, 1, 4'b0000, 0, 0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0);
        vt[15] = mk(0, 1, 4'h6, 3, 4'b0000, 1, 1, 4'b1000, 4'h0, 4'h0, 4'h0, 4'h6);

        @(posedge clk); #1;

        for (int r = 0; r < 16; r++) begin
            rst = vt[r].rst; in_valid = vt[r].iv; d = vt[r].d;
            sel = vt[r].sel; rdy = vt[r].rdy;
            #2;
            if (vt[r].chk_ir) check($sformatf("row%0d in_ready", r), in_ready, vt[r].ir);
            @(posedge clk); #1;
            check($sformatf("row%0d vld", r), vld, vt[r].vld);
            for (int i = 0; i < 4; i++)
                check($sformatf("row%0d y%0d", r, i), ys[i], vt[r].y[i]);
        end

        // Randomized phase: start from a clean reset, then compare to the model.
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            last_y[i] = '0;
        end

        for (int c = 0; c < 400; c++) begin
            logic acc;
            logic exp_ir;
            rst      = ($urandom_range(0, 49) == 0);
            in_valid = $urandom_range(0, 3) != 0;
            d        = W'($urandom);
            sel      = 2'($urandom);
            rdy      = 4'($urandom);
            #2;
            // Room exists if the channel queue is empty or its head leaves now.
            exp_ir = (q[sel].size() == 0) || rdy[sel];
            check("rand in_ready", in_ready, exp_ir);
            acc = !rst && in_valid && exp_ir;
            @(posedge clk); #1;
            if (rst) begin
                for (int i = 0; i < 4; i++) begin
                    q[i].delete();
                    last_y[i] = '0;
                end
            end else begin
                for (int i = 0; i < 4; i++)
                    if (q[i].size() != 0 && rdy[i]) void'(q[i].pop_front());
                if (acc) begin
                    q[sel].push_back(d);
                    last_y[sel] = d;
                end
            end
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rand vld%0d", i), vld[i], q[i].size() != 0);
                check($sformatf("rand y%0d", i), ys[i], last_y[i]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_demux_1_4_stream
